nios_system_nios_cpu_ocimem_arbiter: RTL and testbench

Arbiter and sequencer for the Nios II on-chip-instrumentation (OCI) debug RAM. The RAM is a single-port, 256 x 32 memory. It is shared between two requesters:
- the JTAG debug slave's command path (`take_action_ocimem_a`/`_b` pulses with `jdo`), in the system clock domain;
- the CPU's Avalon debug memory slave.

The block grants at most one RAM access per cycle, returns read data to the winner, and holds the JTAG monitor data register `MonDReg`.

---
 rtl/nios_system_nios_cpu_ocimem_arbiter.sv | 158 +++++++++++++++
 tb/tb_nios_system_nios_cpu_ocimem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios_cpu_ocimem_arbiter.sv
// rtl/nios_system_nios_cpu_ocimem_arbiter.sv - OCI debug RAM arbiter between the JTAG command path and the CPU debug slave
//
// Ports:
//   clk, reset_n                         system clock, synchronous active-low reset
//   take_action_ocimem_a/_b, jdo         JTAG address/read and write command pulses with data
//   cpu_address/read/write/writedata/
//   cpu_byteenable                       CPU Avalon debug slave request
//   cpu_readdata, cpu_waitrequest        CPU Avalon debug slave response
//   ram_addr/wdata/be/we/re, ram_rdata   single-port 256x32 RAM, read data one cycle after ram_re
//   MonDReg                              JTAG monitor data register
//   jtag_busy, jtag_overrun              JTAG request pending / sticky dropped-pulse flag
module nios_system_nios_cpu_ocimem_arbiter #(
  parameter int unsigned JTAG_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [37:0] jdo,
  input  logic [7:0]  cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_rdata,
  output logic [31:0] MonDReg,
  output logic        jtag_busy,
  output logic        jtag_overrun
);

  typedef enum logic {JOP_READ = 1'b0, JOP_WRITE = 1'b1} jop_e;

  localparam logic [3:0] LIMIT = 4'(JTAG_STARVE_LIMIT);

  logic [7:0]  jtag_addr_q, jtag_addr_d;
  logic [31:0] jwdata_q, jwdata_d;
  logic        jpend_q, jpend_d;
  jop_e        jop_q, jop_d;
  logic        jtag_rd_phase_q, jtag_rd_phase_d;
  logic        cpu_rd_phase_q, cpu_rd_phase_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        overrun_q, overrun_d;
  logic [31:0] mondreg_q, mondreg_d;

  logic cpu_elig, grant_jtag, grant_cpu, cpu_wr_grant, cpu_rd_grant;
  logic accept_a, accept_b, drop_pulse;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jtag_busy = jpend_q | jtag_rd_phase_q;

  // A CPU read occupies two cycles; it must not re-arbitrate during its data phase.
  assign cpu_elig     = (cpu_read | cpu_write) & ~cpu_rd_phase_q;
  assign grant_jtag   = jpend_q & (~cpu_elig | (starve_cnt_q == LIMIT));
  assign grant_cpu    = cpu_elig & ~grant_jtag;
  assign cpu_wr_grant = grant_cpu & cpu_write;
  assign cpu_rd_grant = grant_cpu & ~cpu_write;

  // Pulses are only taken while idle; _a wins a same-cycle collision with _b.
  assign accept_a   = take_action_ocimem_a & ~jtag_busy;
  assign accept_b   = take_action_ocimem_b & ~jtag_busy & ~take_action_ocimem_a;
  assign drop_pulse = (take_action_ocimem_a & jtag_busy) |
                      (take_action_ocimem_b & (jtag_busy | take_action_ocimem_a));

  always_comb begin
    ram_addr  = cpu_address;
    ram_wdata = cpu_writedata;
    ram_be    = cpu_byteenable;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (grant_jtag) begin
      ram_addr  = jtag_addr_q;
      ram_wdata = jwdata_q;
      ram_be    = 4'hF;
      ram_we    = (jop_q == JOP_WRITE);
      ram_re    = (jop_q == JOP_READ);
    end else if (grant_cpu) begin
      ram_we = cpu_write;
      ram_re = ~cpu_write;
    end
    // Strobes are derived combinationally, so gate them while reset is held.
    if (!reset_n) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  assign cpu_readdata    = (reset_n && cpu_rd_phase_q) ? ram_rdata : 32'h0;
  assign cpu_waitrequest = ~(reset_n & (cpu_wr_grant | cpu_rd_phase_q));
  assign MonDReg         = mondreg_q;
  assign jtag_overrun    = overrun_q;

  always_comb begin
    jtag_addr_d     = jtag_addr_q;
    jwdata_d        = jwdata_q;
    jpend_d         = jpend_q;
    jop_d           = jop_q;
    jtag_rd_phase_d = grant_jtag & (jop_q == JOP_READ);
    cpu_rd_phase_d  = cpu_rd_grant;
    mondreg_d       = jtag_rd_phase_q ? ram_rdata : mondreg_q;
    overrun_d       = overrun_q | drop_pulse;
    starve_cnt_d    = starve_cnt_q;

    if (grant_jtag) begin
      jpend_d = 1'b0;
      if (jop_q == JOP_WRITE) jtag_addr_d = jtag_addr_q + 8'd1;
    end

    // Accepts and grants are mutually exclusive: a grant implies busy.
    if (accept_a) begin
      jtag_addr_d = jdo[24:17];
      if (jdo[35]) begin
        jpend_d = 1'b1;
        jop_d   = JOP_READ;
      end
    end else if (accept_b) begin
      jwdata_d = jdo[34:3];
      jpend_d  = 1'b1;
      jop_d    = JOP_WRITE;
    end

    if (!jpend_q || grant_jtag) starve_cnt_d = 4'd0;
    else if (grant_cpu && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jtag_addr_q     <= 8'h0;
      jwdata_q        <= 32'h0;
      jpend_q         <= 1'b0;
      jop_q           <= JOP_READ;
      jtag_rd_phase_q <= 1'b0;
      cpu_rd_phase_q  <= 1'b0;
      starve_cnt_q    <= 4'd0;
      overrun_q       <= 1'b0;
      mondreg_q       <= 32'h0;
    end else begin
      jtag_addr_q     <= jtag_addr_d;
      jwdata_q        <= jwdata_d;
      jpend_q         <= jpend_d;
      jop_q           <= jop_d;
      jtag_rd_phase_q <= jtag_rd_phase_d;
      cpu_rd_phase_q  <= cpu_rd_phase_d;
      starve_cnt_q    <= starve_cnt_d;
      overrun_q       <= overrun_d;
      mondreg_q       <= mondreg_d;
    end
  end

endmodule

// File: tb/tb_nios_system_nios_cpu_ocimem_arbiter.sv
// tb/tb_nios_system_nios_cpu_ocimem_arbiter.sv - scoreboard bench for the OCI debug RAM arbiter
module tb_nios_system_nios_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ta, tb;
  logic [37:0] jdo;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [256];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } ram_exp_t;

  ram_exp_t    ram_q[$];
  logic [31:0] cpu_q[$];

  nios_system_nios_cpu_ocimem_arbiter #(.JTAG_STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .jdo(jdo),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM strobe and every CPU read data phase must match the next expectation.
  always @(negedge clk) begin
    if (ram_we || ram_re) begin
      if (ram_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ram_unexpected: got we=%b re=%b addr=%h expected no strobe (cycle %0d)",
                 ram_we, ram_re, ram_addr, cyc);
      end else begin
        ram_exp_t e;
        e = ram_q.pop_front();
        check1("ram_we", ram_we, e.we);
        check1("ram_re", ram_re, ~e.we);
        check32("ram_addr", {24'h0, ram_addr}, {24'h0, e.addr});
        check32("ram_cycle", cyc, e.cyc);
        if (e.we) begin
          check32("ram_wdata", ram_wdata, e.wdata);
          check32("ram_be", {28'h0, ram_be}, {28'h0, e.be});
        end
      end
    end
    if (cpu_read && !cpu_waitrequest) begin
      if (cpu_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cpu_rd_unexpected: got data %h expected no read phase (cycle %0d)",
                 cpu_readdata, cyc);
      end else begin
        check32("cpu_readdata", cpu_readdata, cpu_q.pop_front());
      end
    end
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    return {2'b00, rd, 10'h0, addr, 17'h0};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  task automatic exp_ram(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int c);
    ram_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.cyc = c;
    ram_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // JTAG read held off by back-to-back CPU writes: four CPU grants, then JTAG.
  task automatic starve_round(input logic [7:0] jaddr, input logic [7:0] base, input logic [31:0] jexp);
    int c;
    c = cyc;
    ta = 1'b1; jdo = jdo_a(jaddr, 1'b1);
    tick();
    ta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_write = 1'b1; cpu_address = base + 8'(i);
      cpu_writedata = 32'h4000_0000 + i; cpu_byteenable = 4'hF;
      exp_ram(1'b1, base + 8'(i), 32'h4000_0000 + i, 4'hF, c + 1 + i);
      tick();
    end
    cpu_address = base + 8'd4; cpu_writedata = 32'h4000_0004;
    exp_ram(1'b0, jaddr, 32'h0, 4'h0, c + 5);
    #1;
    check1("starve_cpu_stalled", cpu_waitrequest, 1'b1);
    tick();
    exp_ram(1'b1, base + 8'd4, 32'h4000_0004, 4'hF, c + 6);
    #1;
    check1("starve_cpu_resumes", cpu_waitrequest, 1'b0);
    tick();
    cpu_write = 1'b0;
    #1;
    check32("starve_mondreg", MonDReg, jexp);
    check1("starve_busy", jtag_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_n = 1'b0; ta = 1'b0; tb = 1'b0; jdo = '0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_byteenable = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Preload the RAM model under reset; a pulse coincident with reset must be ignored.
    tick();
    pl_en = 1'b1;
    pl_addr = 8'h10; pl_data = 32'hDEAD_BEEF; tick();
    pl_addr = 8'h20; pl_data = 32'hAAAA_AAAA; tick();
    pl_addr = 8'h50; pl_data = 32'h0BAD_F00D; tick();
    pl_en = 1'b0;
    ta = 1'b1; jdo = jdo_a(8'h10, 1'b1);
    tick();
    ta = 1'b0;
    #1;
    check32("rst_mondreg", MonDReg, 32'h0);
    check1("rst_busy", jtag_busy, 1'b0);
    check1("rst_overrun", jtag_overrun, 1'b0);
    check1("rst_waitreq", cpu_waitrequest, 1'b1);
    check1("rst_we", ram_we, 1'b0);
    check1("rst_re", ram_re, 1'b0);
    check32("rst_readdata", cpu_readdata, 32'h0);
    reset_n = 1'b1;
    tick(); tick();
    check1("post_rst_busy", jtag_busy, 1'b0);
    check1("idle_waitreq", cpu_waitrequest, 1'b1);

    // JTAG read with idle CPU.
    c = cyc;
    ta = 1'b1; jdo = jdo_a(8'h10, 1'b1);
    exp_ram(1'b0, 8'h10, 32'h0, 4'h0, c + 1);
    tick();
    ta = 1'b0;
    #1;
    check1("jrd_busy", jtag_busy, 1'b1);
    tick(); tick();
    check32("jrd_mondreg", MonDReg, 32'hDEAD_BEEF);
    check1("jrd_busy_done", jtag_busy, 1'b0);

    // JTAG write at 0xFF, then address wraps to 0x00.
    c = cyc;
    ta = 1'b1; jdo = jdo_a(8'hFF, 1'b0);
    tick();
    ta = 1'b0; tb = 1'b1; jdo = jdo_b(32'h1234_5678);
    exp_ram(1'b1, 8'hFF, 32'h1234_5678, 4'hF, c + 2);
    tick();
    tb = 1'b0;
    tick();
    check1("jwr_busy_done", jtag_busy, 1'b0);
    tb = 1'b1; jdo = jdo_b(32'hCAFE_F00D);
    exp_ram(1'b1, 8'h00, 32'hCAFE_F00D, 4'hF, c + 4);
    tick();
    tb = 1'b0;
    tick();

    // Uncontended CPU write: zero wait cycles, partial byte enables.
    c = cyc;
    cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'h1111_2222; cpu_byteenable = 4'h3;
    exp_ram(1'b1, 8'h20, 32'h1111_2222, 4'h3, c);
    #1;
    check1("cwr_waitreq", cpu_waitrequest, 1'b0);
    tick();
    cpu_write = 1'b0; cpu_byteenable = 4'h0;

    // Back-to-back CPU reads: one wait cycle each, second granted after first data phase.
    c = cyc;
    cpu_read = 1'b1; cpu_address = 8'h20;
    exp_ram(1'b0, 8'h20, 32'h0, 4'h0, c);
    cpu_q.push_back(32'hAAAA_2222);
    #1;
    check1("crd_wait", cpu_waitrequest, 1'b1);
    tick();
    check1("crd_data_phase", cpu_waitrequest, 1'b0);
    tick();
    cpu_address = 8'h10;
    exp_ram(1'b0, 8'h10, 32'h0, 4'h0, c + 2);
    cpu_q.push_back(32'hDEAD_BEEF);
    tick();
    tick();
    cpu_read = 1'b0;

    // Simultaneous CPU write and JTAG write with the starve counter at zero.
    c = cyc;
    ta = 1'b1; jdo = jdo_a(8'h30, 1'b0);
    tick();
    ta = 1'b0; tb = 1'b1; jdo = jdo_b(32'h55AA_55AA);
    tick();
    tb = 1'b0;
    cpu_write = 1'b1; cpu_address = 8'h31; cpu_writedata = 32'h0102_0304; cpu_byteenable = 4'hF;
    exp_ram(1'b1, 8'h31, 32'h0102_0304, 4'hF, c + 2);
    exp_ram(1'b1, 8'h30, 32'h55AA_55AA, 4'hF, c + 3);
    #1;
    check1("sim_cpu_first", cpu_waitrequest, 1'b0);
    tick();
    cpu_write = 1'b0;
    #1;
    check1("sim_jtag_pending", jtag_busy, 1'b1);
    tick();
    check1("sim_jtag_done", jtag_busy, 1'b0);

    // Starvation, twice: the second round shows the counter restarted from zero.
    starve_round(8'h10, 8'h40, 32'hDEAD_BEEF);
    starve_round(8'h20, 8'h48, 32'hAAAA_2222);

    // Overrun: pulses during a JTAG read in flight are dropped entirely.
    c = cyc;
    ta = 1'b1; jdo = jdo_a(8'h50, 1'b1);
    exp_ram(1'b0, 8'h50, 32'h0, 4'h0, c + 1);
    tick();
    ta = 1'b0; tb = 1'b1; jdo = jdo_b(32'hFFFF_FFFF);
    tick();
    tb = 1'b0; ta = 1'b1; jdo = jdo_a(8'h60, 1'b1);
    #1;
    check1("ovr_set", jtag_overrun, 1'b1);
    tick();
    ta = 1'b0;
    check32("ovr_mondreg", MonDReg, 32'h0BAD_F00D);
    check1("ovr_busy_done", jtag_busy, 1'b0);
    tb = 1'b1; jdo = jdo_b(32'h0000_0077);
    exp_ram(1'b1, 8'h50, 32'h0000_0077, 4'hF, c + 4);
    tick();
    tb = 1'b0;
    tick();
    // Both pulses together: only the address load of _a takes effect.
    ta = 1'b1; tb = 1'b1; jdo = jdo_a(8'h70, 1'b0);
    tick();
    ta = 1'b0; tb = 1'b0;
    check1("both_not_busy", jtag_busy, 1'b0);
    tb = 1'b1; jdo = jdo_b(32'h0000_0099);
    exp_ram(1'b1, 8'h70, 32'h0000_0099, 4'hF, cyc + 1);
    tick();
    tb = 1'b0;
    tick(); tick(); tick();
    check1("ovr_sticky", jtag_overrun, 1'b1);

    // Reset during the JTAG read data phase.
    c = cyc;
    ta = 1'b1; jdo = jdo_a(8'h10, 1'b1);
    exp_ram(1'b0, 8'h10, 32'h0, 4'h0, c + 1);
    tick();
    ta = 1'b0;
    tick();
    reset_n = 1'b0; cpu_read = 1'b1; cpu_address = 8'h20;
    #1;
    check1("rmid_waitreq_low_rst", cpu_waitrequest, 1'b1);
    tick();
    check32("rmid_mondreg", MonDReg, 32'h0);
    check1("rmid_busy", jtag_busy, 1'b0);
    check1("rmid_overrun", jtag_overrun, 1'b0);
    check1("rmid_waitreq", cpu_waitrequest, 1'b1);
    tick();
    cpu_read = 1'b0; reset_n = 1'b1;
    tick(); tick();
    check32("rmid_mondreg_after", MonDReg, 32'h0);

    check32("ram_q_drained", ram_q.size(), 32'd0);
    check32("cpu_q_drained", cpu_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
